rom_fetch: RTL and testbench

Instruction-fetch front end that drives the 12-bit address port of the 4K×8 program ROM and captures the returned byte. It holds a 12-bit program counter and alternates FETCH/EXEC phases under an enable. Each fetched byte is split into a 4-bit instruction nibble and a 4-bit operand nibble. It sits between the program ROM (asynchronous, combinational read) and the downstream decode/ALU logic.

---
 rtl/rom_fetch.sv | 90 +++++++++
 tb/tb_rom_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
// rom_fetch: instruction-fetch front end for the program ROM.
// Holds the program counter, drives the ROM address, and alternates
// FETCH/EXEC phases under enable. Each fetched byte is split into an
// instruction nibble (high half) and an operand nibble (low half).
module rom_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic              phase,
  output logic              valid,
  output logic              pc_wrap
);

  localparam int NIB_W = DATA_W / 2;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] fetch_p1;
  logic              vld_p1;
  logic              wrap_p1;

  // Unsigned increment with the carry-out kept as the top bit; the carry
  // is exactly the "pc was all-ones" condition that raises pc_wrap.
  function automatic logic [ADDR_W:0] pc_inc(input logic [ADDR_W-1:0] p);
    return {1'b0, p} + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

  logic [ADDR_W:0] pc_sum;
  assign pc_sum = pc_inc(pc);

  // Fetch FSM: reset > load > enable > hold. Fetch register is captured
  // only on enabled FETCH edges, so rom_data is ignored at all other times.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      fetch_p1 <= '0;
      vld_p1   <= 1'b0;
      wrap_p1  <= 1'b0;
    end else if (load) begin
      // A jump abandons any pending EXEC so the next enabled edge fetches
      // from the new target; the previously fetched byte stays visible.
      state    <= FETCH;
      pc       <= load_addr;
      vld_p1   <= 1'b0;
      wrap_p1  <= 1'b0;
    end else if (enable) begin
      case (state)
        FETCH: begin
          fetch_p1 <= rom_data;
          pc       <= pc_sum[ADDR_W-1:0];
          state    <= EXEC;
          vld_p1   <= 1'b1;
          wrap_p1  <= pc_sum[ADDR_W];
        end
        default: begin
          state    <= FETCH;
          vld_p1   <= 1'b0;
          wrap_p1  <= 1'b0;
        end
      endcase
    end else begin
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
    end
  end

  // Stage 1 outputs: everything below is a direct view of registers.
  assign rom_addr = pc;
  assign instr    = fetch_p1[DATA_W-1:NIB_W];
  assign oprnd    = fetch_p1[NIB_W-1:0];
  assign phase    = state;
  assign valid    = vld_p1;
  assign pc_wrap  = wrap_p1;

endmodule

// File: tb/tb_rom_fetch.sv
// Testbench for rom_fetch: directed scenarios from the fetch rules plus a
// randomized run compared against a behavioural model of the fetch unit.
module tb_rom_fetch;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [11:0] load_addr;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  instr, oprnd;
  logic        phase, valid, pc_wrap;

  logic [7:0]  mem [0:4095];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [11:0] m_pc;
  logic [7:0]  m_byte;
  logic        m_phase, m_valid, m_wrap;

  always #5 clk = ~clk;

  assign rom_data = mem[rom_addr];

  rom_fetch #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_addr(load_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .oprnd(oprnd), .phase(phase), .valid(valid),
    .pc_wrap(pc_wrap)
  );

  // Drive one clock cycle and advance the model by the same rules.
  task automatic cycle(input logic r, input logic en, input logic ld,
                       input logic [11:0] la);
    reset = r; enable = en; load = ld; load_addr = la;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_byte = 0; m_phase = 0; m_valid = 0; m_wrap = 0;
    end else if (ld) begin
      m_pc = la; m_phase = 0; m_valid = 0; m_wrap = 0;
    end else if (en && !m_phase) begin
      m_byte  = mem[m_pc];
      m_wrap  = (m_pc == 12'hFFF);
      m_pc    = m_pc + 12'd1;
      m_phase = 1; m_valid = 1;
    end else if (en) begin
      m_phase = 0; m_valid = 0; m_wrap = 0;
    end else begin
      m_valid = 0; m_wrap = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 12'h000);
    cycle(1, 1, 0, 12'h000);
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h want=000", rom_addr); end
    checks++; if (instr !== 4'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", instr); end
    checks++; if (oprnd !== 4'h0) begin errors++; $display("FAIL reset_oprnd got=%h want=0", oprnd); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase got=%b want=0", phase); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (pc_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b want=0", pc_wrap); end
  endtask

  task automatic test_sequential();
    cycle(0, 1, 0, 12'h000);
    checks++; if (instr !== 4'hA) begin errors++; $display("FAIL seq1_instr got=%h want=a", instr); end
    checks++; if (oprnd !== 4'h5) begin errors++; $display("FAIL seq1_oprnd got=%h want=5", oprnd); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got=%b want=1", valid); end
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL seq1_phase got=%b want=1", phase); end
    checks++; if (rom_addr !== 12'h001) begin errors++; $display("FAIL seq1_addr got=%h want=001", rom_addr); end
    cycle(0, 1, 0, 12'h000);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL seq2_valid got=%b want=0", valid); end
    checks++; if (rom_addr !== 12'h001) begin errors++; $display("FAIL seq2_addr got=%h want=001", rom_addr); end
    cycle(0, 1, 0, 12'h000);
    checks++; if (instr !== 4'h3) begin errors++; $display("FAIL seq3_instr got=%h want=3", instr); end
    checks++; if (oprnd !== 4'hC) begin errors++; $display("FAIL seq3_oprnd got=%h want=c", oprnd); end
    checks++; if (rom_addr !== 12'h002) begin errors++; $display("FAIL seq3_addr got=%h want=002", rom_addr); end
    cycle(0, 1, 0, 12'h000);
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL seq4_phase got=%b want=0", phase); end
  endtask

  task automatic test_hold();
    // Enter EXEC with the byte at 002 (zero), then hold.
    cycle(0, 1, 0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 12'h000);
      checks++;
      if ({rom_addr, instr, oprnd, phase, valid, pc_wrap} !== {12'h003, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d got addr=%h i=%h o=%h ph=%b v=%b w=%b want addr=003 i=0 o=0 ph=1 v=0 w=0",
                 i, rom_addr, instr, oprnd, phase, valid, pc_wrap);
      end
    end
  endtask

  task automatic test_jump();
    cycle(0, 1, 1, 12'h010);
    checks++; if (rom_addr !== 12'h010) begin errors++; $display("FAIL jump_addr got=%h want=010", rom_addr); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL jump_phase got=%b want=0", phase); end
    checks++; if ({instr, oprnd, valid} !== {4'h0, 4'h0, 1'b0}) begin errors++; $display("FAIL jump_keep got=%h%h v=%b want=00 v=0", instr, oprnd, valid); end
    cycle(0, 1, 0, 12'h000);
    checks++; if ({instr, oprnd} !== 8'h7E) begin errors++; $display("FAIL jump_fetch got=%h%h want=7e", instr, oprnd); end
    checks++; if (rom_addr !== 12'h011) begin errors++; $display("FAIL jump_next got=%h want=011", rom_addr); end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 1, 12'hFFF);
    cycle(0, 1, 0, 12'h000);
    checks++; if ({instr, oprnd} !== 8'h91) begin errors++; $display("FAIL wrap_byte got=%h%h want=91", instr, oprnd); end
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL wrap_addr got=%h want=000", rom_addr); end
    checks++; if (pc_wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got=%b want=1", pc_wrap); end
    cycle(0, 1, 0, 12'h000);
    checks++; if (pc_wrap !== 1'b0) begin errors++; $display("FAIL wrap_once got=%b want=0", pc_wrap); end
    // Load while sitting at all-ones in FETCH with enable high: no wrap.
    cycle(0, 0, 1, 12'hFFF);
    cycle(0, 1, 1, 12'h123);
    checks++; if ({pc_wrap, valid, rom_addr} !== {1'b0, 1'b0, 12'h123}) begin errors++; $display("FAIL load_wrap got w=%b v=%b a=%h want w=0 v=0 a=123", pc_wrap, valid, rom_addr); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 12'h000);
    cycle(0, 1, 0, 12'h000);
    cycle(0, 1, 0, 12'h000);
    cycle(0, 1, 0, 12'h000); // fetch at 001, now EXEC
    checks++; if ({instr, oprnd, phase} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL mid_pre got=%h%h ph=%b want=3c ph=1", instr, oprnd, phase); end
    cycle(1, 1, 0, 12'h000);
    checks++;
    if ({rom_addr, instr, oprnd, phase, valid, pc_wrap} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset got addr=%h i=%h o=%h ph=%b v=%b w=%b want all zero",
               rom_addr, instr, oprnd, phase, valid, pc_wrap);
    end
    cycle(0, 1, 0, 12'h000);
    checks++; if (instr !== 4'hA) begin errors++; $display("FAIL mid_refetch got=%h want=a", instr); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    cycle(1, 0, 0, 12'h000);
    for (int n = 0; n < 600; n++) begin
      logic r, en, ld;
      logic [11:0] la;
      r  = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 9) == 0);
      la = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      cycle(r, en, ld, la);
      checks++;
      if ({rom_addr, instr, oprnd, phase, valid, pc_wrap} !== {m_pc, m_byte, m_phase, m_valid, m_wrap}) begin
        errors++;
        $display("FAIL rand%0d got a=%h d=%h%h ph=%b v=%b w=%b want a=%h d=%h ph=%b v=%b w=%b",
                 n, rom_addr, instr, oprnd, phase, valid, pc_wrap,
                 m_pc, m_byte, m_phase, m_valid, m_wrap);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h000] = 8'hA5;
    mem[12'h001] = 8'h3C;
    mem[12'h010] = 8'h7E;
    mem[12'hFFF] = 8'h91;
    reset = 1; enable = 0; load = 0; load_addr = 0;
    m_pc = 0; m_byte = 0; m_phase = 0; m_valid = 0; m_wrap = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_hold();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
